// File: rtl/serial_to_parallel_deserializer.sv
// Serial-to-parallel deserializer: packs a valid/ready 1-bit stream into W-bit words
// with a registered valid/ready word output and configurable bit order.
module serial_to_parallel_deserializer #(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         serial_valid,
  input  logic         serial_data,
  output logic         serial_ready,
  output logic         parallel_valid,
  output logic [W-1:0] parallel_data,
  input  logic         parallel_ready
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [CW-1:0] cnt;
  logic [W-2:0]  sh;
  logic [W-2:0]  sh_nxt;
  logic [W-1:0]  word_c;
  logic          last;
  logic          accept;

  assign last         = (cnt == LAST);
  // Only the final bit of a word has to wait for the output register to drain.
  assign serial_ready = ~last | ~parallel_valid | parallel_ready;
  assign accept       = serial_valid & serial_ready;
  assign word_c       = MSB_FIRST ? {sh, serial_data} : {serial_data, sh};

  // Place the incoming bit at the slot selected by the bit counter and the bit order.
  always_comb begin
    sh_nxt = sh;
    for (int unsigned i = 0; i < W - 1; i++) begin
      if (cnt == CW'(MSB_FIRST ? (W - 2 - i) : i)) begin
        sh_nxt[i] = serial_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      sh             <= '0;
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
    end else begin
      if (accept && last) begin
        cnt            <= '0;
        parallel_data  <= word_c;
        parallel_valid <= 1'b1;
      end else begin
        if (parallel_ready) begin
          parallel_valid <= 1'b0;
        end
        if (accept) begin
          cnt <= cnt + CW'(1);
          sh  <= sh_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_deserializer.sv
// Bench for serial_to_parallel_deserializer: three instances (W=8 LSB-first, W=8 MSB-first,
// W=4 MSB-first) checked every cycle against a bit-queue word model, plus directed literals.
module tb_serial_to_parallel_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sv;
  logic [2:0] sd;
  logic [2:0] pr;
  wire  [2:0] sr;
  wire  [2:0] pv;
  wire  [7:0] pd0;
  wire  [7:0] pd1;
  wire  [3:0] pd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_to_parallel_deserializer #(.W(8), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .serial_valid(sv[0]), .serial_data(sd[0]), .serial_ready(sr[0]),
    .parallel_valid(pv[0]), .parallel_data(pd0), .parallel_ready(pr[0]));
  serial_to_parallel_deserializer #(.W(8), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .serial_valid(sv[1]), .serial_data(sd[1]), .serial_ready(sr[1]),
    .parallel_valid(pv[1]), .parallel_data(pd1), .parallel_ready(pr[1]));
  serial_to_parallel_deserializer #(.W(4), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .serial_valid(sv[2]), .serial_data(sd[2]), .serial_ready(sr[2]),
    .parallel_valid(pv[2]), .parallel_data(pd2), .parallel_ready(pr[2]));

  function automatic int wi(input int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic bit msb(input int i);
    return (i != 0);
  endfunction

  function automatic logic [7:0] act_pd(input int i);
    case (i)
      0:       return pd0;
      1:       return pd1;
      default: return {4'b0000, pd2};
    endcase
  endfunction

  // Arrival-order bits (col[k] = k-th bit received) mapped to word positions.
  function automatic logic [7:0] order(input int i, input logic [7:0] col);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < wi(i); k++) begin
      if (msb(i)) r[wi(i) - 1 - k] = col[k];
      else        r[k] = col[k];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count of bits collected so far and the output word register.
  int         m_n   [3];
  logic [7:0] m_col [3];
  logic       m_pv  [3];
  logic [7:0] m_pd  [3];

  initial begin
    logic e_sr;
    logic acc;
    logic n_pv;
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_col[i] = '0; m_pv[i] = 1'b0; m_pd[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          m_n[i] = 0; m_col[i] = '0; m_pv[i] = 1'b0; m_pd[i] = '0;
        end
        e_sr = !((m_n[i] == wi(i) - 1) && m_pv[i] && !pr[i]);
        chk($sformatf("serial_ready[%0d]", i), 32'(sr[i]), 32'(e_sr));
        chk($sformatf("parallel_valid[%0d]", i), 32'(pv[i]), 32'(m_pv[i]));
        chk($sformatf("parallel_data[%0d]", i), 32'(act_pd(i)), 32'(m_pd[i]));
        if (rst_n) begin
          acc  = sv[i] && e_sr;
          n_pv = m_pv[i] && !pr[i];
          if (acc) begin
            m_col[i][m_n[i]] = sd[i];
            if (m_n[i] == wi(i) - 1) begin
              m_pd[i] = order(i, m_col[i]);
              n_pv    = 1'b1;
              m_n[i]  = 0;
            end else begin
              m_n[i]++;
            end
          end
          m_pv[i] = n_pv;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of val in the instance's serial order; sv is left high.
  task automatic send_word(input int i, input logic [7:0] val, input int nbits, input bit gap,
                           output int stalls);
    logic ok;
    int   tries;
    stalls = 0;
    for (int k = 0; k < nbits; k++) begin
      if (gap) begin
        while ($urandom_range(1, 0) == 1) begin
          sv[i] = 1'b0;
          sd[i] = 1'($urandom);
          tick();
        end
      end
      sv[i] = 1'b1;
      sd[i] = msb(i) ? val[wi(i) - 1 - k] : val[k];
      tries = 0;
      do begin
        @(negedge clk);
        ok = sr[i];
        tick();
        tries++;
        if (!ok) stalls++;
      end while (!ok && tries < 50);
      if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    end
  endtask

  int st;

  initial begin
    sv = '0; sd = '0; pr = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset mid-word discards partial bits.
    pr[0] = 1'b1;
    send_word(0, 8'hFF, 3, 1'b0, st);
    rst_n = 1'b0;
    #1;
    chk("rst_pv", 32'(pv[0]), 32'd0);
    chk("rst_pd", 32'(pd0), 32'h00);
    chk("rst_sr", 32'(sr[0]), 32'd1);
    sv[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    send_word(0, 8'h3C, 8, 1'b0, st);
    chk("rst_word_pv", 32'(pv[0]), 32'd1);
    chk("rst_word_3c", 32'(pd0), 32'h3C);
    sv[0] = 1'b0;
    tick();

    // LSB-first 0xA5, valid pulses once.
    send_word(0, 8'hA5, 8, 1'b0, st);
    chk("a5_pv", 32'(pv[0]), 32'd1);
    chk("a5_pd", 32'(pd0), 32'hA5);
    sv[0] = 1'b0;
    tick();
    chk("a5_pulse_end", 32'(pv[0]), 32'd0);

    // Back-to-back words with no stalls.
    send_word(0, 8'h01, 8, 1'b0, st);
    chk("b2b_stall1", 32'(st), 32'd0);
    chk("b2b_pd01", 32'(pd0), 32'h01);
    send_word(0, 8'h80, 8, 1'b0, st);
    chk("b2b_stall2", 32'(st), 32'd0);
    chk("b2b_pv2", 32'(pv[0]), 32'd1);
    chk("b2b_pd80", 32'(pd0), 32'h80);
    sv[0] = 1'b0;
    tick();

    // Backpressure: final bit of second word waits for the consumer.
    pr[0] = 1'b0;
    send_word(0, 8'hFF, 8, 1'b0, st);
    send_word(0, 8'h0F, 7, 1'b0, st);
    chk("bp_first7_stall", 32'(st), 32'd0);
    sd[0] = 1'b0;
    @(negedge clk);
    chk("bp_sr_low", 32'(sr[0]), 32'd0);
    chk("bp_hold_ff", 32'(pd0), 32'hFF);
    tick();
    chk("bp_still_ff", 32'(pd0), 32'hFF);
    pr[0] = 1'b1;
    @(negedge clk);
    chk("bp_sr_rise", 32'(sr[0]), 32'd1);
    tick();
    sv[0] = 1'b0;
    chk("bp_pv_stays", 32'(pv[0]), 32'd1);
    chk("bp_pd_0f", 32'(pd0), 32'h0F);
    tick();
    chk("bp_drained", 32'(pv[0]), 32'd0);

    // Gapped input.
    send_word(0, 8'h5A, 8, 1'b1, st);
    chk("gap_pd5a", 32'(pd0), 32'h5A);
    sv[0] = 1'b0;
    pr[0] = 1'b0;
    tick();

    // MSB-first, W=8 and W=4.
    pr[1] = 1'b1; pr[2] = 1'b1;
    send_word(1, 8'hC1, 8, 1'b0, st);
    chk("msb_c1", 32'(pd1), 32'hC1);
    sv[1] = 1'b0;
    send_word(2, 8'h09, 4, 1'b0, st);
    chk("msb_w4_9", 32'(pd2), 32'h9);
    sv[2] = 1'b0;
    tick();

    // Random traffic with occasional resets on all instances.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        sv[i] = ($urandom_range(3, 0) != 0);
        sd[i] = 1'($urandom);
        pr[i] = ($urandom_range(2, 0) != 0);
      end
      rst_n = ($urandom_range(299, 0) != 0);
      tick();
    end
    rst_n = 1'b1;
    sv = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_deserializer.md
# serial_to_parallel_deserializer

Collects a 1-bit serial stream into W-bit parallel words. It is the receive-side counterpart of a mux-based parallel-to-serial selector: one input line fans out over time into the bit positions of an output word. Both sides use a valid/ready handshake. The block sits between a serial link front-end and word-oriented consumer logic.

## Interface

Parameters:
- `W`, default 8: output word width; legal W ≥ 2.
- `MSB_FIRST`, default 0: 0 means the first serial bit lands in bit 0; 1 means the first serial bit lands in bit W-1.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `serial_valid`, in, 1: `serial_data` carries a bit this cycle.
- `serial_data`, in, 1: serial bit.
- `serial_ready`, out, 1: the block accepts a bit this cycle.
- `parallel_valid`, out, 1: `parallel_data` holds a complete word.
- `parallel_data`, out, W: assembled word.
- `parallel_ready`, in, 1: the consumer takes the word this cycle.

## Operation

State:
- Bit counter `cnt`, $clog2(W) bits, range 0..W-1.
- Shift register `sh`, W-1 bits, holds the partial word.
- Output register holds `parallel_data` and `parallel_valid`.

Serial handshake:
- A bit is accepted when `serial_valid & serial_ready`.
- `serial_ready = (cnt != W-1) | ~parallel_valid | parallel_ready`. This is a combinational path from `parallel_ready`; that path is intended.
- When `cnt < W-1`, a bit is always accepted, even if a word is waiting downstream.

On accept with `cnt < W-1`:
- The bit is stored in `sh` at the position set by `MSB_FIRST`.
- `cnt` increments.

On accept with `cnt == W-1`:
- The output register loads `{sh, bit}` in the configured order.
- `parallel_valid` is set to 1.
- `cnt` returns to 0.

Parallel handshake:
- A word is transferred when `parallel_valid & parallel_ready`.
- After a transfer, `parallel_valid` clears unless a new word loads in the same cycle. In that case `parallel_valid` stays 1 and the new data replaces the old.
- While `parallel_valid=1 & parallel_ready=0`, `parallel_data` stays stable.

Bit ordering:
- `MSB_FIRST=0`: the first accepted bit goes to `parallel_data[0]` and the last to `[W-1]`.
- `MSB_FIRST=1`: the reverse.

Other rules:
- No bits are dropped or duplicated. Cycles with `serial_valid=0` leave `cnt` and `sh` unchanged.
- Reset, including mid-word: `cnt=0`, `sh=0`, `parallel_valid=0`, `parallel_data=0`. Any partial word is discarded. `serial_ready` reads 1 during and right after reset.

## Timing

- Latency: `parallel_valid` rises on the clock edge that accepts the W-th bit, so it is visible in the following cycle.
- Throughput: one bit per cycle sustained when `parallel_ready=1`. Word n+1's final bit can be accepted in the same cycle word n is taken.
- Backpressure: `serial_ready` drops only while `cnt==W-1`, `parallel_valid=1` and `parallel_ready=0`. It rises in the same cycle `parallel_ready` rises.
- Reset deassertion is synchronized externally. The first accept can occur on the first edge after `rst_n` goes high.

## Test plan

All scenarios use W=8 unless stated.

1. Reset: assert `rst_n=0` mid-stream -> immediately `parallel_valid=0`, `parallel_data=0x00`, `serial_ready=1`. After release, 8 bits of 0x3C -> word 0x3C. The pre-reset partial bits do not appear.
2. `MSB_FIRST=0`, `parallel_ready=1`: send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> `parallel_valid` pulses 1 cycle after the 8th bit with `parallel_data=0xA5`.
3. Back-to-back words: 0x01 then 0x80, `serial_valid` held high for 16 cycles, `parallel_ready=1` -> two valid pulses 8 cycles apart, no stall cycles (`serial_ready` stays 1).
4. Backpressure: `parallel_ready=0`, send 0xFF then 0x0F -> the second word's first 7 bits are accepted. `serial_ready=0` at the 8th bit, and `parallel_data` holds 0xFF. Raise `parallel_ready` -> 0xFF transfers, 0x0F loads in the same cycle, and `parallel_valid` stays 1.
5. Gapped input: 0x5A sent with a random 0/1 `serial_valid` pattern -> word 0x5A. Idle cycles cause no counter change.
6. `MSB_FIRST=1`: send bits 1,1,0,0,0,0,0,1 -> `parallel_data=0xC1`. Repeat with W=4, bits 1,0,0,1 -> 0x9.
